// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bundle: level strobes from the core,
// registered ready/rdata/busy/err back from the memory target.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output addr, wdata, re, we,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  addr, wdata, re, we,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target with programmable wait states and a
// four-phase ready handshake, used in place of a zero-latency RAM.
module mem_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus
);
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;
    logic              op_strobe;
    logic              mem_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    // A strobe switch (re->we or back) reads as the latched op's strobe dropping.
    assign op_strobe = op_wr ? bus.we : bus.re;

    // Gated by reset level so an edge seen while reset is held cannot commit a write.
    assign mem_wr = reset && (state == WAIT) && op_wr && op_strobe && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[addr_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.re ^ bus.we) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        op_wr   <= bus.we;
                        cnt     <= WAIT_INIT;
                        state   <= WAIT;
                    end else if (bus.re && bus.we) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!op_strobe) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state   <= ACK;
                        ready_q <= 1'b1;
                        if (!op_wr)
                            rdata_q <= mem[addr_q];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    if (!op_strobe) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed 16-bit memory target that answers the processor core's read-enable/write-enable requests.
- Sits on the core's memory port, opposite the control-unit/datapath initiator.
- Adds a configurable wait-state count and a four-phase ready handshake, so the core can be exercised against slow memory.
- Replaces the zero-latency behavioural RAM in system simulation.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, word address width; DEPTH = 2**ADDR_W words, so every address is valid.
- WAIT_CYC, 2, wait-state cycles inserted before each access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- addr  input  ADDR_W  word address from core.
- wdata  input  DATA_W  write data from core.
- re  input  1  read request strobe, level, held by core until ready.
- we  input  1  write request strobe, level, held by core until ready.
- rdata  output  DATA_W  read data, valid while ready=1 after a read.
- ready  output  1  access complete; held until core drops its strobe.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  one-cycle pulse on an illegal request (re and we both high).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rdata=0, ready=0, busy=0, err=0, wait counter=0, latched op/addr/wdata=0.
  - Memory array is not cleared.
  - Reset mid-WAIT aborts the transaction; no write occurs.
- Registered outputs: all outputs are registered; busy is decoded from the state register.
- FSM states:
  - IDLE: ready=0.
    - re xor we at edge n: latch addr, wdata and op (read/write); load counter=WAIT_CYC; go to WAIT.
    - re and we both high: err=1 for the following cycle only; no latch, no access; stay IDLE.
    - Neither strobe: stay IDLE; err=0.
  - WAIT:
    - Each edge: if the latched op's strobe is low, abort to IDLE (no access, no ready).
    - Else if counter==0, go to ACK; else decrement the counter.
    - ACK is therefore entered at edge n+WAIT_CYC+1 for all WAIT_CYC, including 0.
    - addr/wdata changes during WAIT are ignored; the latched values are used.
  - ACK:
    - On the entering edge, a write stores the latched wdata at the latched addr; a read loads rdata from mem[latched addr].
    - ready=1 from that edge onward.
    - Stays in ACK while the op's strobe is high.
    - Strobe low at an edge: go to IDLE with ready=0.
    - rdata holds its value after ACK until the next read completes.
    - A write ACK leaves rdata unchanged.
- Release phase: a strobe still high in the cycle after ready falls cannot occur, because ACK is left only when the strobe is low. A new request is accepted only from IDLE, so no double access is possible.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Strobe switching from re to we while in WAIT/ACK counts as the latched op's strobe dropping: abort in WAIT, release in ACK. The new op is taken from IDLE.
- err is never asserted outside IDLE.

Test Plan:
- Reset: hold reset=0 with mem preloaded -> rdata=0, ready=0, busy=0, err=0. Release reset; read addr 0x05 (preloaded 0xBEEF) -> rdata=0xBEEF.
- Write then read, WAIT_CYC=2:
  - we=1, addr=0x10, wdata=0x1234 accepted at edge n -> busy=1 after n; ready=1 after edge n+3.
  - Drop we -> ready=0 next edge.
  - re=1, addr=0x10 -> ready after 3 further edges, rdata=0x1234.
- Latency sweep: WAIT_CYC=0 -> ready after edge n+1. WAIT_CYC=15 -> ready after edge n+16. Change addr during WAIT -> latched address used.
- Abort: we=1, addr=0x20, wdata=0xAAAA; drop we after 1 WAIT cycle -> ready never rises; later read of 0x20 returns its old value (0x0000).
- Illegal and held strobe:
  - re=we=1 in IDLE -> err=1 for exactly one cycle, busy=0, no memory change.
  - Hold re=1 for 5 cycles after ready -> single access, ready stays 1, no second transaction.
- Async reset mid-WAIT: assert reset=0 during WAIT of a write to 0x30 -> outputs zero immediately; mem[0x30] unchanged; the next transaction completes normally.
